// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V pipeline: decoded packet and issue-unit state.
package riscv_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_BEQ = 4'd3,
    OP_BNE = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_JAL = 4'd7
  } op_t;

  typedef struct packed {
    logic [63:0] seq;
    logic [31:0] addr;
    logic [31:0] addr_next;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] immed;
    logic [31:0] data;
    op_t         op;
  } idu_t;

  typedef enum logic [0:0] {
    ISU_IDLE = 1'b0,
    ISU_WAIT = 1'b1
  } isu_state_t;

endpackage

// File: rtl/riscv_regfile.sv
// Architectural register file: 32x32, two combinational read ports with
// same-cycle write bypass, one write port, x0 reads as zero.
module riscv_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rd_idx_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_idx_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_r [32];

  // Clear every register on reset; otherwise commit write-back (x0 discarded).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en && (wr_idx != 5'd0)) begin
      regs_r[wr_idx] <= wr_data;
    end
  end

  // Port A: zero for x0, forward a same-cycle write, else the stored value.
  always_comb begin
    rd_data_a = 32'd0;
    if (rd_idx_a == 5'd0) begin
      rd_data_a = 32'd0;
    end else if (wr_en && (wr_idx == rd_idx_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_r[rd_idx_a];
    end
  end

  // Port B: same read rule as port A.
  always_comb begin
    rd_data_b = 32'd0;
    if (rd_idx_b == 5'd0) begin
      rd_data_b = 32'd0;
    end else if (wr_en && (wr_idx == rd_idx_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_r[rd_idx_b];
    end
  end

endmodule

// File: rtl/riscv_isu.sv
// In-order issue unit: buffers decoded packets, filters stale sequence
// numbers, issues one instruction per retire handshake and reads operands.
module riscv_isu
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  idu_t                       in_idu,
  output logic                       exu_vld,
  output idu_t                       exu_idu,
  output logic [31:0]                rs1_data,
  output logic [31:0]                rs2_data,
  input  logic                       register_write_en,
  input  logic [4:0]                 register_write,
  input  logic [31:0]                register_write_data,
  input  logic                       exu_retire,
  input  logic                       flush,
  input  logic [63:0]                flush_seq,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  idu_t             fifo_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [63:0]      exp_seq_r;
  isu_state_t       state_r;
  isu_state_t       state_nxt_s;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             issue_s;
  idu_t             head_s;
  logic [31:0]      rf_rs1_s;
  logic [31:0]      rf_rs2_s;

  logic             exu_vld_r;
  idu_t             exu_idu_r;
  logic [31:0]      rs1_data_r;
  logic [31:0]      rs2_data_r;

  assign full_s    = (occ_r == OCC_W'(DEPTH));
  assign empty_s   = (occ_r == {OCC_W{1'b0}});
  assign head_s    = fifo_r[rd_ptr_r];
  // A packet is consumed whenever accepted; only the expected seq is kept.
  assign push_s    = in_vld && !full_s && !flush && (in_idu.seq == exp_seq_r);
  assign in_rdy    = !full_s;
  assign occupancy = occ_r;
  assign exu_vld   = exu_vld_r;
  assign exu_idu   = exu_idu_r;
  assign rs1_data  = rs1_data_r;
  assign rs2_data  = rs2_data_r;

  riscv_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rd_idx_a  (head_s.rs1),
    .rd_data_a (rf_rs1_s),
    .rd_idx_b  (head_s.rs2),
    .rd_data_b (rf_rs2_s),
    .wr_en     (register_write_en),
    .wr_idx    (register_write),
    .wr_data   (register_write_data)
  );

  // Issue decision: flush forces IDLE; a retire in WAIT frees the slot.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    if (flush) begin
      state_nxt_s = ISU_IDLE;
    end else begin
      case (state_r)
        ISU_IDLE: begin
          if (!empty_s) begin
            issue_s     = 1'b1;
            state_nxt_s = ISU_WAIT;
          end else begin
            state_nxt_s = ISU_IDLE;
          end
        end
        ISU_WAIT: begin
          if (exu_retire) begin
            if (!empty_s) begin
              issue_s     = 1'b1;
              state_nxt_s = ISU_WAIT;
            end else begin
              state_nxt_s = ISU_IDLE;
            end
          end else begin
            state_nxt_s = ISU_WAIT;
          end
        end
        default: begin
          state_nxt_s = ISU_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= in_idu;
    end
  end

  // Pointers, occupancy and expected sequence; flush resynchronises all.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      exp_seq_r <= 64'd0;
    end else if (flush) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      exp_seq_r <= flush_seq;
    end else begin
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + 1'b1;
        exp_seq_r <= exp_seq_r + 64'd1;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, issue_s})
        2'b10:   occ_r <= occ_r + 1'b1;
        2'b01:   occ_r <= occ_r - 1'b1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ISU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Issue outputs: pulse valid, capture packet and operands on issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      exu_vld_r  <= 1'b0;
      exu_idu_r  <= '0;
      rs1_data_r <= 32'd0;
      rs2_data_r <= 32'd0;
    end else begin
      exu_vld_r <= issue_s;
      if (issue_s) begin
        exu_idu_r  <= head_s;
        rs1_data_r <= rf_rs1_s;
        rs2_data_r <= rf_rs2_s;
      end
    end
  end

endmodule

// File: tb/tb_riscv_isu.sv
// Randomised and directed bench for riscv_isu against a queue-based model.
module tb_riscv_isu;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_vld;
  logic        in_rdy;
  idu_t        in_idu;
  logic        exu_vld;
  idu_t        exu_idu;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        register_write_en;
  logic [4:0]  register_write;
  logic [31:0] register_write_data;
  logic        exu_retire;
  logic        flush;
  logic [63:0] flush_seq;
  logic [2:0]  occupancy;

  riscv_isu #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_idu(in_idu), .exu_vld(exu_vld), .exu_idu(exu_idu),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .register_write_en(register_write_en), .register_write(register_write),
    .register_write_data(register_write_data), .exu_retire(exu_retire),
    .flush(flush), .flush_seq(flush_seq), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  idu_t        mq[$];
  logic [63:0] m_exp;
  bit          m_busy;
  logic [31:0] m_regs [32];
  bit          m_vld;
  idu_t        m_idu;
  logic [31:0] m_rs1, m_rs2;

  // Bench-side EXU behaviour
  int          ret_cnt = 0;
  bit          auto_exu = 1'b1;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic idu_t rand_pkt(input logic [63:0] seq);
    idu_t p;
    p.seq       = seq;
    p.addr      = $urandom;
    p.addr_next = $urandom;
    p.rs1       = 5'($urandom_range(0, 31));
    p.rs2       = 5'($urandom_range(0, 31));
    p.rd        = 5'($urandom_range(0, 31));
    p.immed     = $urandom;
    p.data      = $urandom;
    p.op        = op_t'($urandom_range(0, 7));
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (register_write_en && register_write == idx) return register_write_data;
    return m_regs[idx];
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int   sz;
    bit   issue;
    idu_t head;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      m_exp = 64'd0; m_busy = 1'b0; m_vld = 1'b0; m_idu = '0;
      m_rs1 = 32'd0; m_rs2 = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      return;
    end
    issue = !flush && sz > 0 && (!m_busy || exu_retire);
    m_vld = issue;
    if (issue) begin
      head   = mq.pop_front();
      m_idu  = head;
      m_rs1  = m_read(head.rs1);
      m_rs2  = m_read(head.rs2);
      m_busy = 1'b1;
    end else if (flush || exu_retire) begin
      m_busy = 1'b0;
    end
    if (in_vld && sz < DEPTH && !flush && in_idu.seq == m_exp) begin
      mq.push_back(in_idu);
      m_exp = m_exp + 64'd1;
    end
    if (flush) begin
      mq.delete();
      m_exp = flush_seq;
    end
    if (register_write_en && register_write != 5'd0)
      m_regs[register_write] = register_write_data;
  endtask

  task automatic compare_all();
    check("in_rdy", 256'(in_rdy), 256'(mq.size() < DEPTH));
    check("occupancy", 256'(occupancy), 256'(mq.size()));
    check("exu_vld", 256'(exu_vld), 256'(m_vld));
    check("exu_idu", 256'(exu_idu), 256'(m_idu));
    if (m_vld) begin
      check("rs1_data", 256'(rs1_data), 256'(m_rs1));
      check("rs2_data", 256'(rs2_data), 256'(m_rs2));
    end
  endtask

  // Default inputs for the next cycle, with the EXU retiring when due.
  task automatic prep();
    in_vld = 1'b0; flush = 1'b0; reset = 1'b0; exu_retire = 1'b0;
    register_write_en = 1'b0; register_write = 5'd0; register_write_data = 32'd0;
    if (auto_exu && ret_cnt > 0) begin
      ret_cnt--;
      if (ret_cnt == 0) begin
        exu_retire = 1'b1;
        register_write_en = 1'b1;
        register_write = pend_rd;
        register_write_data = pend_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    if (reset || flush) ret_cnt = 0;
    if (m_vld) begin
      ret_cnt = 2;
      pend_rd = m_idu.rd;
      pend_data = m_idu.data;
    end
  endtask

  task automatic push(input idu_t p);
    in_vld = 1'b1;
    in_idu = p;
  endtask

  task automatic do_reset();
    prep(); reset = 1'b1; tick(); tick();
  endtask

  int   seen_k[$];
  int   seen_seq[$];
  idu_t p;

  initial begin
    in_idu = '0; flush_seq = 64'd0;
    do_reset();
    check("rst_exu_vld", 256'(exu_vld), 256'(0));
    check("rst_in_rdy", 256'(in_rdy), 256'(1));
    check("rst_occ", 256'(occupancy), 256'(0));
    check("rst_exu_idu", 256'(exu_idu), 256'(0));
    check("rst_rs1", 256'(rs1_data), 256'(0));

    // Four in-order packets; seq0 writes x5 which seq1 reads via bypass.
    for (int k = 0; k < 12; k++) begin
      prep();
      if (k < 4) begin
        p = rand_pkt(64'(k));
        p.op = OP_BEQ;
        if (k == 0) begin p.rd = 5'd5; p.data = 32'h1234; end
        if (k == 1) p.rs1 = 5'd5;
        push(p);
      end
      tick();
      if (k == 3) check("bypass_rs1", 256'(rs1_data), 256'(32'h1234));
      if (exu_vld) begin seen_k.push_back(k); seen_seq.push_back(int'(exu_idu.seq)); end
    end
    check("t1_issue_cnt", 256'(seen_k.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < seen_k.size()) begin
        check("t1_issue_cycle", 256'(seen_k[i]), 256'(2 * i + 1));
        check("t1_issue_seq", 256'(seen_seq[i]), 256'(i));
      end
    end

    // Flush on seq0 retire, then a stale and a correct-path packet.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      prep();
      push(rand_pkt(64'(k)));
      if (k == 3) begin flush = 1'b1; flush_seq = 64'd9; end
      tick();
    end
    check("flush_occ", 256'(occupancy), 256'(0));
    check("flush_no_issue", 256'(exu_vld), 256'(0));
    seen_seq.delete();
    for (int k = 0; k < 8; k++) begin
      prep();
      if (k == 0) push(rand_pkt(64'd4));
      if (k == 1) push(rand_pkt(64'd9));
      tick();
      if (exu_vld) seen_seq.push_back(int'(exu_idu.seq));
    end
    check("flush_issue_cnt", 256'(seen_seq.size()), 256'(1));
    if (seen_seq.size() > 0) check("flush_issue_seq", 256'(seen_seq[0]), 256'(9));

    // Hold retire low and overfill the FIFO.
    do_reset();
    auto_exu = 1'b0;
    for (int k = 0; k < 6; k++) begin
      prep();
      push(rand_pkt(64'(k)));
      tick();
      if (k == 4) begin
        check("full_in_rdy", 256'(in_rdy), 256'(0));
        check("full_occ", 256'(occupancy), 256'(4));
      end
    end
    prep(); exu_retire = 1'b1; tick();
    check("full_retire_rdy", 256'(in_rdy), 256'(1));
    auto_exu = 1'b1;
    for (int k = 0; k < 12; k++) begin prep(); tick(); end

    // Writes to x0 are discarded, including the same-cycle bypass.
    do_reset();
    prep(); register_write_en = 1'b1; register_write = 5'd0; register_write_data = 32'hFFFF_FFFF; tick();
    p = rand_pkt(64'd0); p.rs1 = 5'd0; p.rs2 = 5'd0;
    prep(); push(p); tick();
    prep(); register_write_en = 1'b1; register_write = 5'd0; register_write_data = 32'hFFFF_FFFF; tick();
    check("x0_rs1", 256'(rs1_data), 256'(0));
    check("x0_rs2", 256'(rs2_data), 256'(0));

    // Reset while waiting for a retire; a late retire must be ignored.
    do_reset();
    prep(); register_write_en = 1'b1; register_write = 5'd5; register_write_data = 32'hABCD; tick();
    prep(); push(rand_pkt(64'd0)); tick();
    prep(); tick();
    prep(); reset = 1'b1; tick();
    prep(); exu_retire = 1'b1; tick();
    check("rstw_exu_vld", 256'(exu_vld), 256'(0));
    check("rstw_occ", 256'(occupancy), 256'(0));
    prep(); tick();
    check("rstw_idle_vld", 256'(exu_vld), 256'(0));
    p = rand_pkt(64'd0); p.rs1 = 5'd5; p.rs2 = 5'd5;
    prep(); push(p); tick();
    prep(); tick();
    check("rstw_reg_cleared", 256'(rs1_data), 256'(0));

    // Randomised traffic with flushes, resets and stray write-backs.
    for (int k = 0; k < 3000; k++) begin
      prep();
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 9) < 8) push(rand_pkt(m_exp));
        else push(rand_pkt(m_exp + 64'($urandom_range(1, 3))));
      end
      if (!register_write_en && $urandom_range(0, 4) == 0) begin
        register_write_en = 1'b1;
        register_write = 5'($urandom_range(0, 31));
        register_write_data = $urandom;
      end
      if ($urandom_range(0, 99) < 3) begin
        flush = 1'b1;
        flush_seq = m_exp + 64'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
